mem_bus_arbiter: RTL and testbench

- Shares one single-beat memory port between the instruction-fetch requester (i-side) and the load/store requester (d-side).
- Sits between the core's fetch/memory stages and the downstream memory interface.
- Grants one requester at a time, registers the granted request onto the memory port, and routes addr_ok/data_ok back only to the granted side.
- Fixed d-side priority by default, so a stalled memory stage is never starved by fetch.

---
 rtl/mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-beat memory port between the instruction-fetch
// requester (i-side) and the load/store requester (d-side).
//
// One transaction is in flight at a time. The winning request is latched into the mreq_*
// registers, and addr_ok/data_ok are routed back only to the side that holds the grant.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined -> fixed d-side priority, so a stalled memory stage is never starved by fetch
//   defined   -> with both sides requesting, the grant goes to the side opposite the last
//                completed grant; a lone request is always granted

module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned IDATA_W = 32,
    parameter int unsigned DDATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,

    // Instruction-fetch side
    input  logic                   ireq_valid,
    input  logic [ADDR_W-1:0]      ireq_addr,
    output logic                   i_addr_ok,
    output logic                   i_data_ok,
    output logic [IDATA_W-1:0]     i_data,

    // Load/store side
    input  logic                   dreq_valid,
    input  logic [ADDR_W-1:0]      dreq_addr,
    input  logic                   dreq_write,
    input  logic [2:0]             dreq_size,
    input  logic [DDATA_W/8-1:0]   dreq_strobe,
    input  logic [DDATA_W-1:0]     dreq_wdata,
    output logic                   d_addr_ok,
    output logic                   d_data_ok,
    output logic [DDATA_W-1:0]     d_data,

    // Downstream memory port
    output logic                   mreq_valid,
    output logic [ADDR_W-1:0]      mreq_addr,
    output logic                   mreq_write,
    output logic [2:0]             mreq_size,
    output logic [DDATA_W/8-1:0]   mreq_strobe,
    output logic [DDATA_W-1:0]     mreq_wdata,
    input  logic                   mreq_ready,
    input  logic                   mresp_valid,
    input  logic [DDATA_W-1:0]     mresp_rdata,

    // Status
    output logic                   busy,
    output logic                   grant_d
);

    // Fetches are always 32-bit reads.
    localparam logic [2:0] FetchSize = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;

    logic                   r_mreq_valid;
    logic                   w_mreq_valid_d;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      w_addr_d;
    logic                   r_write;
    logic                   w_write_d;
    logic [2:0]             r_size;
    logic [2:0]             w_size_d;
    logic [DDATA_W/8-1:0]   r_strobe;
    logic [DDATA_W/8-1:0]   w_strobe_d;
    logic [DDATA_W-1:0]     r_wdata;
    logic [DDATA_W-1:0]     w_wdata_d;
    logic                   r_grant_d;
    logic                   w_grant_d_d;

    logic                   w_pick_d;
    logic                   w_req_fire;
    logic                   w_resp_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = d-side wins the next tie; flips to the side opposite each completed grant.
    logic                   r_prio_d;

    // Tie-break pointer: reset prefers d-side, then tracks the last completed grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_d <= 1'b1;
        end else if (w_resp_fire) begin
            r_prio_d <= ~r_grant_d;
        end
    end

    // Arbitration: a lone request always wins; a tie goes to the pointed-at side.
    always_comb begin
        w_pick_d = dreq_valid & (~ireq_valid | r_prio_d);
    end
`else
    // Arbitration: fixed d-side priority.
    always_comb begin
        w_pick_d = dreq_valid;
    end
`endif

    // Handshake qualifiers. A response is only accepted while a transaction is
    // outstanding, including one that completes in the same cycle it is accepted.
    always_comb begin
        w_req_fire  = r_mreq_valid & mreq_ready;
        w_resp_fire = mresp_valid &
                      ((r_state == StResp) | ((r_state == StReq) & mreq_ready));
    end

    // Next-state logic and request latching.
    always_comb begin
        w_state_d      = r_state;
        w_mreq_valid_d = r_mreq_valid;
        w_addr_d       = r_addr;
        w_write_d      = r_write;
        w_size_d       = r_size;
        w_strobe_d     = r_strobe;
        w_wdata_d      = r_wdata;
        w_grant_d_d    = r_grant_d;

        unique case (r_state)
            StIdle: begin
                if (w_pick_d) begin
                    w_addr_d       = dreq_addr;
                    w_write_d      = dreq_write;
                    w_size_d       = dreq_size;
                    w_strobe_d     = dreq_strobe;
                    w_wdata_d      = dreq_wdata;
                    w_grant_d_d    = 1'b1;
                    w_mreq_valid_d = 1'b1;
                    w_state_d      = StReq;
                end else if (ireq_valid) begin
                    w_addr_d       = ireq_addr;
                    w_write_d      = 1'b0;
                    w_size_d       = FetchSize;
                    w_strobe_d     = '0;
                    w_wdata_d      = '0;
                    w_grant_d_d    = 1'b0;
                    w_mreq_valid_d = 1'b1;
                    w_state_d      = StReq;
                end
            end

            StReq: begin
                if (mreq_ready) begin
                    w_mreq_valid_d = 1'b0;
                    // A response in the acceptance cycle finishes the transaction outright.
                    w_state_d      = mresp_valid ? StIdle : StResp;
                end
            end

            StResp: begin
                if (mresp_valid) begin
                    w_state_d = StIdle;
                end
            end

            default: begin
                w_state_d      = StIdle;
                w_mreq_valid_d = 1'b0;
            end
        endcase
    end

    // State and latched-request registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_mreq_valid <= 1'b0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_strobe     <= '0;
            r_wdata      <= '0;
            r_grant_d    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_mreq_valid <= w_mreq_valid_d;
            r_addr       <= w_addr_d;
            r_write      <= w_write_d;
            r_size       <= w_size_d;
            r_strobe     <= w_strobe_d;
            r_wdata      <= w_wdata_d;
            r_grant_d    <= w_grant_d_d;
        end
    end

    // Output routing: handshakes go only to the granted side.
    always_comb begin
        mreq_valid  = r_mreq_valid;
        mreq_addr   = r_addr;
        mreq_write  = r_write;
        mreq_size   = r_size;
        mreq_strobe = r_strobe;
        mreq_wdata  = r_wdata;

        i_addr_ok   = w_req_fire & ~r_grant_d;
        d_addr_ok   = w_req_fire &  r_grant_d;
        i_data_ok   = w_resp_fire & ~r_grant_d;
        d_data_ok   = w_resp_fire &  r_grant_d;

        i_data      = mresp_rdata[IDATA_W-1:0];
        d_data      = mresp_rdata;

        busy        = (r_state != StIdle);
        grant_d     = r_grant_d;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later,
// well before the falling edge. Honours MEM_ARB_ROUND_ROBIN_EN for the arbitration run.

module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned IDATA_W = 32;
    localparam int unsigned DDATA_W = 64;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 ireq_valid;
    logic [ADDR_W-1:0]    ireq_addr;
    logic                 i_addr_ok;
    logic                 i_data_ok;
    logic [IDATA_W-1:0]   i_data;
    logic                 dreq_valid;
    logic [ADDR_W-1:0]    dreq_addr;
    logic                 dreq_write;
    logic [2:0]           dreq_size;
    logic [DDATA_W/8-1:0] dreq_strobe;
    logic [DDATA_W-1:0]   dreq_wdata;
    logic                 d_addr_ok;
    logic                 d_data_ok;
    logic [DDATA_W-1:0]   d_data;
    logic                 mreq_valid;
    logic [ADDR_W-1:0]    mreq_addr;
    logic                 mreq_write;
    logic [2:0]           mreq_size;
    logic [DDATA_W/8-1:0] mreq_strobe;
    logic [DDATA_W-1:0]   mreq_wdata;
    logic                 mreq_ready;
    logic                 mresp_valid;
    logic [DDATA_W-1:0]   mresp_rdata;
    logic                 busy;
    logic                 grant_d;

    int n_checks = 0;
    int n_pass   = 0;

    mem_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .IDATA_W (IDATA_W),
        .DDATA_W (DDATA_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .i_addr_ok   (i_addr_ok),
        .i_data_ok   (i_data_ok),
        .i_data      (i_data),
        .dreq_valid  (dreq_valid),
        .dreq_addr   (dreq_addr),
        .dreq_write  (dreq_write),
        .dreq_size   (dreq_size),
        .dreq_strobe (dreq_strobe),
        .dreq_wdata  (dreq_wdata),
        .d_addr_ok   (d_addr_ok),
        .d_data_ok   (d_data_ok),
        .d_data      (d_data),
        .mreq_valid  (mreq_valid),
        .mreq_addr   (mreq_addr),
        .mreq_write  (mreq_write),
        .mreq_size   (mreq_size),
        .mreq_strobe (mreq_strobe),
        .mreq_wdata  (mreq_wdata),
        .mreq_ready  (mreq_ready),
        .mresp_valid (mresp_valid),
        .mresp_rdata (mresp_rdata),
        .busy        (busy),
        .grant_d     (grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, ready to drive inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Give combinational outputs time to settle after driving inputs.
    task automatic settle();
        #3;
    endtask

    initial begin
        rst         = 1'b1;
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_write  = 1'b0;
        dreq_size   = 3'd0;
        dreq_strobe = '0;
        dreq_wdata  = '0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_rdata = '0;

        next_cycle();
        next_cycle();
        rst = 1'b0;
        settle();
        check("rst_busy",      64'(busy),       64'd0);
        check("rst_mvalid",    64'(mreq_valid), 64'd0);
        check("rst_maddr",     mreq_addr,       64'd0);
        check("rst_grant_d",   64'(grant_d),    64'd0);
        check("rst_oks",       64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'd0);

        // ---- Single fetch: N (drive), N+1 (ready), N+2 (response) ----
        next_cycle();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0000;
        settle();
        check("f_n_mvalid",    64'(mreq_valid), 64'd0);
        next_cycle();
        mreq_ready = 1'b1;
        settle();
        check("f_mvalid",      64'(mreq_valid), 64'd1);
        check("f_maddr",       mreq_addr,       64'h8000_0000);
        check("f_mwrite",      64'(mreq_write), 64'd0);
        check("f_msize",       64'(mreq_size),  64'd2);
        check("f_i_addr_ok",   64'(i_addr_ok),  64'd1);
        check("f_d_addr_ok",   64'(d_addr_ok),  64'd0);
        check("f_grant_d",     64'(grant_d),    64'd0);
        next_cycle();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        mresp_rdata = 64'h0000_0000_0000_0013;
        settle();
        check("f_i_data_ok",   64'(i_data_ok),  64'd1);
        check("f_i_data",      64'(i_data),     64'h13);
        check("f_d_data_ok",   64'(d_data_ok),  64'd0);
        check("f_mvalid_off",  64'(mreq_valid), 64'd0);
        next_cycle();
        ireq_valid  = 1'b0;
        mresp_valid = 1'b0;
        settle();
        check("f_idle",        64'(busy),       64'd0);

        // ---- Simultaneous requests: d first, then i after one dead cycle ----
        next_cycle();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0000;
        dreq_valid = 1'b1;
        dreq_addr  = 64'h8000_1000;
        dreq_write = 1'b0;
        dreq_size  = 3'd3;
        mreq_ready = 1'b1;
        next_cycle();
        settle();
        check("s1_grant_d",    64'(grant_d),    64'd1);
        check("s1_maddr",      mreq_addr,       64'h8000_1000);
        check("s1_d_addr_ok",  64'(d_addr_ok),  64'd1);
        check("s1_i_addr_ok",  64'(i_addr_ok),  64'd0);
        next_cycle();
        mresp_valid = 1'b1;
        mresp_rdata = 64'h1122_3344_5566_7788;
        settle();
        check("s1_d_data_ok",  64'(d_data_ok),  64'd1);
        check("s1_d_data",     d_data,          64'h1122_3344_5566_7788);
        check("s1_i_data_ok",  64'(i_data_ok),  64'd0);
        check("s1_resp_aok",   64'(d_addr_ok),  64'd0);
        next_cycle();
        dreq_valid  = 1'b0;
        mresp_valid = 1'b0;
        settle();
        check("s_dead_busy",   64'(busy),       64'd0);
        next_cycle();
        settle();
        check("s2_grant_d",    64'(grant_d),    64'd0);
        check("s2_maddr",      mreq_addr,       64'h8000_0000);
        check("s2_i_addr_ok",  64'(i_addr_ok),  64'd1);
        next_cycle();
        mresp_valid = 1'b1;
        mresp_rdata = 64'hAAAA_BBBB_0000_0013;
        settle();
        check("s2_i_data_ok",  64'(i_data_ok),  64'd1);
        check("s2_i_data",     64'(i_data),     64'h13);
        next_cycle();
        ireq_valid  = 1'b0;
        mresp_valid = 1'b0;

        // ---- Both valids held for four transactions ----
        next_cycle();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0040;
        dreq_valid = 1'b1;
        dreq_addr  = 64'h8000_2040;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = RoundRobin ? ((k % 2) == 0) : 1'b1;
            next_cycle();
            settle();
            check($sformatf("arb%0d_grant_d", k), 64'(grant_d), 64'(exp_d));
            check($sformatf("arb%0d_maddr", k), mreq_addr,
                  exp_d ? 64'h8000_2040 : 64'h8000_0040);
            next_cycle();
            mresp_valid = 1'b1;
            mresp_rdata = 64'(k);
            settle();
            check($sformatf("arb%0d_ok", k), 64'({d_data_ok, i_data_ok}),
                  exp_d ? 64'b10 : 64'b01);
            next_cycle();
            mresp_valid = 1'b0;
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        mreq_ready = 1'b0;
        next_cycle();

        // ---- Store with three stalled cycles; requester fields change meanwhile ----
        next_cycle();
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8000_3000;
        dreq_write  = 1'b1;
        dreq_size   = 3'd3;
        dreq_strobe = 8'hFF;
        dreq_wdata  = 64'h0000_0000_DEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            dreq_addr  = 64'h1234_0000 + 64'(k);
            dreq_wdata = 64'h5555_0000 + 64'(k);
            settle();
            check($sformatf("st%0d_mvalid", k), 64'(mreq_valid), 64'd1);
            check($sformatf("st%0d_maddr", k), mreq_addr, 64'h8000_3000);
            check($sformatf("st%0d_wdata", k), mreq_wdata, 64'h0000_0000_DEAD_BEEF);
            check($sformatf("st%0d_wr_strb", k), 64'({mreq_write, mreq_strobe}),
                  64'h1FF);
            check($sformatf("st%0d_d_addr_ok", k), 64'(d_addr_ok), 64'd0);
        end
        next_cycle();
        mreq_ready = 1'b1;
        settle();
        check("st_d_addr_ok",  64'(d_addr_ok),  64'd1);
        check("st_wdata_rdy",  mreq_wdata,      64'h0000_0000_DEAD_BEEF);
        next_cycle();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        mresp_rdata = '0;
        settle();
        check("st_d_data_ok",  64'(d_data_ok),  64'd1);
        check("st_d_aok_off",  64'(d_addr_ok),  64'd0);
        next_cycle();
        dreq_valid  = 1'b0;
        dreq_write  = 1'b0;
        mresp_valid = 1'b0;

        // ---- Coincident ready and response in the REQ cycle ----
        next_cycle();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0100;
        next_cycle();
        mreq_ready  = 1'b1;
        mresp_valid = 1'b1;
        mresp_rdata = 64'hFFFF_FFFF_0000_0093;
        settle();
        check("co_i_addr_ok",  64'(i_addr_ok),  64'd1);
        check("co_i_data_ok",  64'(i_data_ok),  64'd1);
        check("co_i_data",     64'(i_data),     64'h93);
        next_cycle();
        ireq_valid  = 1'b0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        settle();
        check("co_idle",       64'(busy),       64'd0);
        check("co_mvalid",     64'(mreq_valid), 64'd0);

        // ---- Reset while waiting for a response ----
        next_cycle();
        dreq_valid = 1'b1;
        dreq_addr  = 64'h8000_4000;
        next_cycle();
        mreq_ready = 1'b1;
        settle();
        check("rr_d_addr_ok",  64'(d_addr_ok),  64'd1);
        next_cycle();
        mreq_ready = 1'b0;
        dreq_valid = 1'b0;
        rst        = 1'b1;
        settle();
        check("rr_resp_busy",  64'(busy),       64'd1);
        next_cycle();
        rst         = 1'b0;
        mresp_valid = 1'b1;
        mresp_rdata = 64'hCAFE;
        settle();
        check("rr_oks",        64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'd0);
        check("rr_mvalid",     64'(mreq_valid), 64'd0);
        check("rr_busy",       64'(busy),       64'd0);
        check("rr_grant_d",    64'(grant_d),    64'd0);
        next_cycle();
        mresp_valid = 1'b0;
        settle();
        check("rr_stay_idle",  64'(busy),       64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
